// File: rtl/accel_pkg.sv
// accel_pkg: shared definitions for the accelerator sequencing master.
//   - Word offsets of the accelerator register window (write and read maps).
//   - Status register done-bit position.
//   - Sequencer state enum and write-data select enum.
// Optional feature macro: ACCEL_SEQ_READBACK_EN adds the ST_RB state.
package accel_pkg;

  // Write map
  localparam logic [4:0] OFF_GO     = 5'd0;
  localparam logic [4:0] OFF_KEY0   = 5'd2;
  localparam logic [4:0] OFF_PT0    = 5'd6;
  // Read map
  localparam logic [4:0] OFF_STATUS = 5'd8;
  localparam logic [4:0] OFF_RKEY0  = 5'd10;
  localparam logic [4:0] OFF_RPT0   = 5'd14;
  localparam logic [4:0] OFF_CT0    = 5'd18;

  localparam int STATUS_DONE_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_PT,
`ifdef ACCEL_SEQ_READBACK_EN
    ST_RB,
`endif
    ST_GO,
    ST_POLL,
    ST_RD_CT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    WSEL_NONE,
    WSEL_KEY,
    WSEL_PT,
    WSEL_GO
  } wsel_e;

endpackage

// File: rtl/accel_seq_addrgen.sv
// accel_seq_addrgen: combinational bus-cycle decode for the sequencer.
//   state_i  - sequencer state the bus cycle belongs to
//   idx_i    - word index within the state (0..3, or 0..7 for readback)
//   addr_o   - byte address (0 when not selected)
//   wr_en_o  - write strobe
//   sel_o    - chip select
//   wsel_o   - which source drives write data
// Optional feature macro: ACCEL_SEQ_READBACK_EN (readback address decode).
module accel_seq_addrgen
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  state_e      state_i,
  input  logic [2:0]  idx_i,
  output logic [31:0] addr_o,
  output logic        wr_en_o,
  output logic        sel_o,
  output wsel_e       wsel_o
);

  logic [4:0] off;

  always_comb begin
    off     = OFF_GO;
    wr_en_o = 1'b0;
    sel_o   = 1'b0;
    wsel_o  = WSEL_NONE;
    case (state_i)
      ST_WR_KEY: begin off = OFF_KEY0 + {2'b0, idx_i}; wr_en_o = 1'b1; sel_o = 1'b1; wsel_o = WSEL_KEY; end
      ST_WR_PT:  begin off = OFF_PT0  + {2'b0, idx_i}; wr_en_o = 1'b1; sel_o = 1'b1; wsel_o = WSEL_PT;  end
`ifdef ACCEL_SEQ_READBACK_EN
      // key and pt readback words are contiguous: idx 0..3 key, 4..7 pt
      ST_RB:     begin off = OFF_RKEY0 + {2'b0, idx_i}; sel_o = 1'b1; end
`endif
      ST_GO:     begin off = OFF_GO; wr_en_o = 1'b1; sel_o = 1'b1; wsel_o = WSEL_GO; end
      ST_POLL:   begin off = OFF_STATUS; sel_o = 1'b1; end
      ST_RD_CT:  begin off = OFF_CT0 + {2'b0, idx_i}; sel_o = 1'b1; end
      default:   ;
    endcase
    // BASE_ADDR[6:0] is zero, so OR-ing in the offset is an add
    addr_o = sel_o ? (BASE_ADDR | {25'b0, off, 2'b00}) : 32'h0;
  end

endmodule

// File: rtl/accel_seq_master.sv
// accel_seq_master: bus initiator that loads key/plaintext into the
// encryption co-processor, kicks it, polls done with a timeout and reads
// back the cyphertext.
//   clk, rst                 - clock, async active-high reset
//   req_valid/req_ready      - upstream request handshake (ready only in IDLE)
//   req_key, req_pt          - 128-bit key / plaintext, word0 = [31:0]
//   rsp_valid                - one-cycle response pulse
//   rsp_ct, rsp_err          - cyphertext and error, held until next accept
//   busy                     - state != IDLE
//   m_addr, m_wr_en,
//   m_accel_select, m_wdata  - registered accelerator bus outputs
//   m_rdata                  - accelerator read data (combinational in m_addr)
// Optional feature macro: ACCEL_SEQ_READBACK_EN reads key/pt back after
// loading them and aborts with rsp_err on any mismatch.
module accel_seq_master
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CW             = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_pt,
  output logic         rsp_valid,
  output logic [127:0] rsp_ct,
  output logic         rsp_err,
  output logic         busy,
  output logic [31:0]  m_addr,
  output logic         m_wr_en,
  output logic         m_accel_select,
  output logic [31:0]  m_wdata,
  input  logic [31:0]  m_rdata
);

  localparam logic [CW:0] TIMEOUT_W = (CW+1)'(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW:0]    cnt_inc;
  logic [127:0]   key_q, key_d, pt_q, pt_d, ct_q, ct_d, rsp_ct_q, rsp_ct_d;
  logic           err_q, err_d, rsp_vld_q, rsp_vld_d;
  logic [31:0]    m_addr_q, m_wdata_q, wdata_d;
  logic           m_wr_q, m_sel_q;

  logic [31:0]    ag_addr;
  logic           ag_wr, ag_sel;
  wsel_e          ag_wsel;

`ifdef ACCEL_SEQ_READBACK_EN
  logic [31:0] rb_exp;
  assign rb_exp = idx_q[2] ? pt_q[{idx_q[1:0], 5'b0} +: 32] : key_q[{idx_q[1:0], 5'b0} +: 32];
`endif

  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    err_d     = err_q;
    rsp_ct_d  = rsp_ct_q;
    rsp_vld_d = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d  = ST_WR_KEY;
        idx_d    = 3'd0;
        key_d    = req_key;
        pt_d     = req_pt;
        ct_d     = '0;
        err_d    = 1'b0;
        rsp_ct_d = '0;
      end
      ST_WR_KEY: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) begin state_d = ST_WR_PT; idx_d = 3'd0; end
      end
      ST_WR_PT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) begin
`ifdef ACCEL_SEQ_READBACK_EN
          state_d = ST_RB;
`else
          state_d = ST_GO;
`endif
          idx_d = 3'd0;
        end
      end
`ifdef ACCEL_SEQ_READBACK_EN
      ST_RB: begin
        idx_d = idx_q + 3'd1;
        if (m_rdata != rb_exp) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (idx_q == 3'd7) begin
          state_d = ST_GO;
          idx_d   = 3'd0;
        end
      end
`endif
      ST_GO: begin
        state_d = ST_POLL;
        cnt_d   = '0;
      end
      ST_POLL: begin
        if (m_rdata[STATUS_DONE_BIT]) begin
          state_d = ST_RD_CT;
          idx_d   = 3'd0;
        end else begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (cnt_inc >= TIMEOUT_W) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RD_CT: begin
        ct_d[{idx_q[1:0], 5'b0} +: 32] = m_rdata;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Response fields are loaded on RESP entry so rsp_ct only changes there
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      rsp_vld_d = 1'b1;
      rsp_ct_d  = ct_d;
    end
  end

  // Bus outputs are decoded from the next state so the registered bus
  // cycle lines up with state_q; m_rdata then answers the current state.
  accel_seq_addrgen #(.BASE_ADDR(BASE_ADDR)) u_addrgen (
    .state_i (state_d),
    .idx_i   (idx_d),
    .addr_o  (ag_addr),
    .wr_en_o (ag_wr),
    .sel_o   (ag_sel),
    .wsel_o  (ag_wsel)
  );

  always_comb begin
    wdata_d = 32'h0;
    case (ag_wsel)
      WSEL_KEY: wdata_d = key_d[{idx_d[1:0], 5'b0} +: 32];
      WSEL_PT:  wdata_d = pt_d[{idx_d[1:0], 5'b0} +: 32];
      WSEL_GO:  wdata_d = 32'h1;
      default:  wdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      pt_q      <= '0;
      ct_q      <= '0;
      err_q     <= 1'b0;
      rsp_ct_q  <= '0;
      rsp_vld_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wr_q    <= 1'b0;
      m_sel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      err_q     <= err_d;
      rsp_ct_q  <= rsp_ct_d;
      rsp_vld_q <= rsp_vld_d;
      m_addr_q  <= ag_addr;
      m_wdata_q <= wdata_d;
      m_wr_q    <= ag_wr;
      m_sel_q   <= ag_sel;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = ~req_ready;
  assign rsp_valid      = rsp_vld_q;
  assign rsp_ct         = rsp_ct_q;
  assign rsp_err        = err_q;
  assign m_addr         = m_addr_q;
  assign m_wr_en        = m_wr_q;
  assign m_accel_select = m_sel_q;
  assign m_wdata        = m_wdata_q;

endmodule

// File: tb/tb_accel_seq_master.sv
// Bench for accel_seq_master with a behavioural accelerator responder.
module tb_accel_seq_master;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef ACCEL_SEQ_READBACK_EN
  localparam int RBX = 8;
`else
  localparam int RBX = 0;
`endif
  localparam logic [127:0] CT_STD = 128'h000000A3_000000A2_000000A1_000000A0;

  logic         clk, rst, req_valid, req_ready, rsp_valid, rsp_err, busy;
  logic [127:0] req_key, req_pt, rsp_ct;
  logic [31:0]  m_addr, m_wdata, m_rdata;
  logic         m_wr_en, m_accel_select;

  accel_seq_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(64), .CW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_pt(req_pt), .rsp_valid(rsp_valid), .rsp_ct(rsp_ct),
    .rsp_err(rsp_err), .busy(busy), .m_addr(m_addr), .m_wr_en(m_wr_en),
    .m_accel_select(m_accel_select), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder controls (driven by the test)
  int poll_zero = 0;
  bit never_done = 0, stale_mode = 0, corrupt_mode = 0;

  // responder state
  logic [31:0] rkey [4];
  logic [31:0] rpt  [4];
  bit          armed = 0;
  int          rcnt = 0;
  logic        done;
  logic [4:0]  off;
  assign off = m_addr[6:2];

  always_comb done = armed ? (!never_done && rcnt >= poll_zero) : stale_mode;

  always_comb begin
    m_rdata = 32'h0;
    if (off == 5'd8) m_rdata = {done, 30'd0, armed};
    else if (off >= 5'd10 && off <= 5'd13) begin
      m_rdata = rkey[2'(off - 5'd10)];
      if (corrupt_mode && off == 5'd12) m_rdata = m_rdata ^ 32'h0000_0100;
    end
    else if (off >= 5'd14 && off <= 5'd17) m_rdata = rpt[2'(off - 5'd14)];
    else if (off >= 5'd18 && off <= 5'd21) m_rdata = 32'hA0 + 32'(off - 5'd18);
  end

  always @(posedge clk) begin
    if (rst) begin
      armed <= 0;
      rcnt  <= 0;
    end else begin
      if (rsp_valid) armed <= 0;
      if (m_accel_select && m_wr_en) begin
        if (off == 5'd0 && m_wdata[0]) begin armed <= 1; rcnt <= 0; end
        else if (off >= 5'd2 && off <= 5'd5) rkey[2'(off - 5'd2)] <= m_wdata;
        else if (off >= 5'd6 && off <= 5'd9) rpt[2'(off - 5'd6)]  <= m_wdata;
      end else if (armed) rcnt <= rcnt + 1;
    end
  end

  // bus / response monitor
  int cyc = 0, acc_cyc = 0, lat = 0, rsp_n = 0;
  int wr_n = 0, poll_n = 0, ctrd_n = 0, go_n = 0, bad_base = 0;
  logic [4:0]   wr_offs [16];
  logic [127:0] last_ct = '0;
  logic         last_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      acc_cyc <= cyc; wr_n <= 0; poll_n <= 0; ctrd_n <= 0; go_n <= 0;
    end else if (!rst) begin
      if (m_accel_select) begin
        if (m_addr[31:7] != BASE[31:7]) bad_base <= bad_base + 1;
        if (m_wr_en) begin
          if (wr_n < 16) wr_offs[wr_n[3:0]] <= off;
          wr_n <= wr_n + 1;
          if (off == 5'd0) go_n <= go_n + 1;
        end
        else if (off == 5'd8)  poll_n <= poll_n + 1;
        else if (off >= 5'd18) ctrd_n <= ctrd_n + 1;
      end
      if (rsp_valid) begin
        rsp_n <= rsp_n + 1; lat <= cyc - acc_cyc; last_ct <= rsp_ct; last_err <= rsp_err;
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] key, pt;
    int           pz;
    bit           never, stale;
    logic [127:0] ct;
    bit           err;
    int           lat, polls, ctrd;
  } vec_t;

  vec_t vecs [4];

  task automatic do_req(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    req_key = k; req_pt = p; req_valid = 1'b1;
    chk("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, input int n0);
    int k = 0;
    while (rsp_n == n0 && k < bound) begin @(negedge clk); k++; end
    chk("rsp_seen", rsp_n != n0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int n0;
    logic [44:0] act_w, exp_w;
    poll_zero = v.pz; never_done = v.never; stale_mode = v.stale;
    n0 = rsp_n;
    do_req(v.key, v.pt);
    wait_rsp(300, n0);
    chk("rsp_ct", last_ct, v.ct);
    chk("rsp_err", last_err, v.err);
    chk("latency", lat, v.lat);
    chk("poll_cycles", poll_n, v.polls);
    chk("ct_reads", ctrd_n, v.ctrd);
    chk("go_writes", go_n, 1);
    chk("write_count", wr_n, 9);
    for (int i = 0; i < 9; i++) begin
      act_w[i*5 +: 5] = wr_offs[i];
      exp_w[i*5 +: 5] = (i < 8) ? 5'(i + 2) : 5'd0;
    end
    chk("write_offsets", act_w, exp_w);
    chk("key_written", {rkey[3], rkey[2], rkey[1], rkey[0]}, v.key);
    chk("pt_written",  {rpt[3], rpt[2], rpt[1], rpt[0]}, v.pt);
    stale_mode = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n0, bad;
    vecs[0] = '{128'h00000004_00000003_00000002_00000001, 128'h00000008_00000007_00000006_00000005,
                1, 0, 0, CT_STD, 0, 16 + RBX, 2, 4};
    vecs[1] = '{128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF, 128'h80000000_00000001_CAFEF00D_12345678,
                0, 0, 0, CT_STD, 0, 15 + RBX, 1, 4};
    vecs[2] = '{128'h11111111_22222222_33333333_44444444, 128'h55555555_66666666_77777777_88888888,
                0, 1, 0, 128'h0, 1, 74 + RBX, 64, 0};
    vecs[3] = '{128'h0000000F_0000000E_0000000D_0000000C, 128'hF0000000_E0000000_D0000000_C0000000,
                2, 0, 1, CT_STD, 0, 17 + RBX, 3, 4};

    req_valid = 0; req_key = '0; req_pt = '0;
    rst = 1'b1;
    #12;
    chk("reset_bus", {m_addr, m_wr_en, m_accel_select, m_wdata}, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, busy}, 0);
    chk("reset_ct", rsp_ct, 0);
    chk("reset_ready", req_ready, 1);
    @(negedge clk); rst = 1'b0;

    // table: normal, fast done, timeout, stale done before go
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // reset while polling aborts with no response
    never_done = 1;
    n0 = rsp_n;
    do_req(vecs[1].key, vecs[1].pt);
    bad = 0;
    while (poll_n < 5 && bad < 100) begin @(negedge clk); bad++; end
    chk("reached_poll", poll_n >= 5, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_bus", {m_addr, m_wr_en, m_accel_select, m_wdata}, 0);
    chk("abort_rsp", {rsp_valid, rsp_err, busy}, 0);
    chk("abort_ct", rsp_ct, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", rsp_n, n0);
    never_done = 0;
    run_vec(vecs[0]);

    // req_valid held high: ready low while busy, back-to-back restart
    poll_zero = 1;
    @(negedge clk);
    req_key = vecs[1].key; req_pt = vecs[1].pt; req_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy && req_ready) bad++;
      if (rsp_valid) break;
    end
    chk("held_rsp", rsp_valid, 1);
    chk("held_ready_low", bad, 0);
    chk("ready_in_resp", req_ready, 0);
    @(negedge clk);
    chk("ready_after_resp", {req_ready, busy}, 2'b10);
    @(negedge clk);
    chk("second_start", {busy, m_wr_en, m_addr}, {2'b11, BASE | 32'h8});
    req_valid = 1'b0;
    n0 = rsp_n;
    wait_rsp(300, n0);
    chk("second_ct", last_ct, CT_STD);
    chk("second_err", last_err, 0);

`ifdef ACCEL_SEQ_READBACK_EN
    // corrupted key[2] readback aborts before go
    corrupt_mode = 1;
    n0 = rsp_n;
    do_req(vecs[0].key, vecs[0].pt);
    wait_rsp(300, n0);
    chk("rb_err", last_err, 1);
    chk("rb_no_go", go_n, 0);
    chk("rb_no_poll", poll_n, 0);
    chk("rb_latency", lat, 12);
    corrupt_mode = 0;
`endif

    chk("base_addr", bad_base, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
